// File: rtl/cpu_pkg.sv
// cpu_pkg: shared loader states, byte width and fetch-error causes for the instruction memory.
package cpu_pkg;
    localparam int BYTE_W      = 8;
    localparam int INSTR_BYTES = 4;
    typedef enum logic [1:0] {IDLE, LOAD, READY} ldr_state_e;
    typedef enum logic [1:0] {ERR_NONE, MISALIGN, RANGE, NOTLOADED} err_cause_e;
endpackage

// File: rtl/cpu_instrmem_ram.sv
// cpu_instrmem_ram: word-wide synchronous RAM with byte-lane write enables and a registered read port.
module cpu_instrmem_ram import cpu_pkg::*; #(
    parameter int DEPTH_WORDS     = 16384,
    parameter int BYTES_PER_INSTR = INSTR_BYTES,
    localparam int W    = BYTE_W * BYTES_PER_INSTR,
    localparam int WA_W = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [BYTES_PER_INSTR-1:0] wlane,
    input  logic [WA_W-1:0]            waddr,
    input  logic [W-1:0]               wdata,
    input  logic                       re,
    input  logic [WA_W-1:0]            raddr,
    output logic [W-1:0]               rdata
);
    logic [W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES_PER_INSTR; i++)
            if (we && wlane[i]) mem[waddr][BYTE_W*i +: BYTE_W] <= wdata[BYTE_W*i +: BYTE_W];
    end

    // Only the read register is reset; the array itself keeps its contents.
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/cpu_instrmem_ldr.sv
// cpu_instrmem_ldr: instruction memory filled by a byte-serial loader, with a validated
// one-cycle-latency big-endian fetch port.
module cpu_instrmem_ldr import cpu_pkg::*; #(
    parameter int ADDR_W          = 16,
    parameter int DEPTH_WORDS     = 16384,
    parameter int BYTES_PER_INSTR = INSTR_BYTES,
    parameter int INSTR_W         = BYTE_W * BYTES_PER_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_start,
    input  logic               ld_valid,
    input  logic [7:0]         ld_byte,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               ld_done,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  addr,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_vld,
    output logic               err
);
    localparam int NBYTES = DEPTH_WORDS * BYTES_PER_INSTR;
    localparam int CNT_W  = NBYTES > 1 ? $clog2(NBYTES) : 1;
    localparam int WA_W   = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam int AX_W   = ADDR_W + 1;

    ldr_state_e                 state, state_d;
    logic [CNT_W-1:0]           cnt, cnt_d, lane;
    logic                       we, cnt_last, fetch_err;
    logic [BYTES_PER_INSTR-1:0] wlane;
    logic [INSTR_W-1:0]         rdata;
    err_cause_e                 cause;

    assign ld_ready = state == LOAD;
    assign ld_done  = state == READY;
    assign cnt_last = cnt == CNT_W'(NBYTES - 1);
    assign lane     = cnt % CNT_W'(BYTES_PER_INSTR);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        we      = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (ld_start) cnt_d = '0;
                else if (ld_valid) begin
                    we      = 1'b1;
                    cnt_d   = cnt + CNT_W'(1);
                    state_d = (ld_last || cnt_last) ? READY : LOAD;
                end
            end
            READY: begin
                if (ld_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte offset 0 lands in the most significant lane (big-endian).
    always_comb begin
        wlane = '0;
        for (int i = 0; i < BYTES_PER_INSTR; i++) wlane[i] = lane == CNT_W'(BYTES_PER_INSTR - 1 - i);
    end

    always_comb begin
        cause = (addr % ADDR_W'(BYTES_PER_INSTR)) != '0 ? MISALIGN :
                (AX_W'(addr) / AX_W'(BYTES_PER_INSTR)) >= AX_W'(DEPTH_WORDS) ? RANGE :
                state != READY ? NOTLOADED : ERR_NONE;
        fetch_err = cause != ERR_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            instr_vld <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            instr_vld <= rd_en;
            if (rd_en) err <= fetch_err;
        end
    end

    // Failed fetches leave the RAM idle; the held error flag masks its stale word.
    cpu_instrmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .BYTES_PER_INSTR(BYTES_PER_INSTR)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .wlane (wlane),
        .waddr (WA_W'(cnt / CNT_W'(BYTES_PER_INSTR))),
        .wdata ({BYTES_PER_INSTR{ld_byte}}),
        .re    (rd_en && !fetch_err),
        .raddr (WA_W'(addr / ADDR_W'(BYTES_PER_INSTR))),
        .rdata (rdata)
    );

    assign instr = err ? '0 : rdata;

    a_err_zero: assert property (@(posedge clk) disable iff (rst) (instr_vld && err) |-> instr == '0);
endmodule
